// File: rtl/led_frame_sched_if.sv
//==============================================================================
// Module      : led_frame_sched_if
// Description : Handshake bundle between the frame scheduler, the GPMC pixel
//               FIFO read port and the LED string serializers.
//               Signals:
//                 fifo_empty    FIFO -> sched   pixel FIFO empty
//                 fifo_rd_en    sched -> FIFO   pop strobe
//                 fifo_rd_data  FIFO -> sched   pixel, valid one cycle after pop
//                 ser_valid     sched -> ser    pixel offered
//                 ser_ready     ser -> sched    pixel accepted
//                 ser_chan      sched -> ser    target string of ser_data
//                 ser_data      sched -> ser    pixel to serialize
//                 ser_latch     sched -> ser    latch/reset period active
//               Modports: master (scheduler side), slave (FIFO/serializer side).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface led_frame_sched_if #(
    parameter int NUM_CHAN = 2,
    parameter int PIX_W    = 24
);
    localparam int c_CHAN_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

    logic                fifo_empty;
    logic                fifo_rd_en;
    logic [PIX_W-1:0]    fifo_rd_data;
    logic                ser_valid;
    logic                ser_ready;
    logic [c_CHAN_W-1:0] ser_chan;
    logic [PIX_W-1:0]    ser_data;
    logic                ser_latch;

    modport master (
        input  fifo_empty, fifo_rd_data, ser_ready,
        output fifo_rd_en, ser_valid, ser_chan, ser_data, ser_latch
    );

    modport slave (
        output fifo_empty, fifo_rd_data, ser_ready,
        input  fifo_rd_en, ser_valid, ser_chan, ser_data, ser_latch
    );
endinterface

`default_nettype wire

// File: rtl/led_frame_sched.sv
//==============================================================================
// Module      : led_frame_sched
// Description : Frame scheduler between the GPMC pixel FIFO and the LED string
//               serializers. Pops pixels one at a time and deals them
//               round-robin over NUM_CHAN strings, closes each frame with a
//               latch period of LATCH_CYCLES and an inter-frame gap taken from
//               hblank_cycles, and reports busy / frame_done / frame_count /
//               sticky underrun to the register bank.
// Ports       : clk, rst_n (async, active low)
//               enable         start frames, sampled only in IDLE
//               hblank_cycles  inter-frame gap, captured at latch exit
//               underrun_clr   clears the sticky underrun flag
//               busy           high outside IDLE
//               frame_done     one-cycle pulse after the latch period
//               frame_count    completed frames, wraps at 16 bits
//               underrun       sticky FIFO starvation flag
//               bus            led_frame_sched_if.master (FIFO + serializer)
//               brightness     [7:0], only with LED_SCHED_BRIGHTNESS_EN
// Config      : `define LED_SCHED_BRIGHTNESS_EN adds the brightness input and
//               a scaling stage (c*(brightness+1))>>8 per 8-bit colour field,
//               raising pop-to-valid latency from 2 to 3 cycles.
//               PIX_W is expected to be a multiple of 8 for that stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module led_frame_sched #(
    parameter int NUM_CHAN        = 2,
    parameter int PIX_W           = 24,
    parameter int LEDS_PER_CHAN   = 150,
    parameter int LATCH_CYCLES    = 8000,
    parameter int UNDERRUN_CYCLES = 1024,
    parameter int HBLANK_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [HBLANK_W-1:0] hblank_cycles,
`ifdef LED_SCHED_BRIGHTNESS_EN
    input  logic [7:0]          brightness,
`endif
    input  logic                underrun_clr,
    output logic                busy,
    output logic                frame_done,
    output logic [15:0]         frame_count,
    output logic                underrun,
    led_frame_sched_if.master   bus
);

    localparam int c_CHAN_W    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int c_TOTAL_PIX = NUM_CHAN * LEDS_PER_CHAN;
    localparam int c_PIX_CNT_W = (c_TOTAL_PIX > 1) ? $clog2(c_TOTAL_PIX) : 1;
    localparam int c_LATCH_W   = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam int c_STALL_W   = $clog2(UNDERRUN_CYCLES + 1);

    localparam logic [c_CHAN_W-1:0]    c_LAST_CHAN  = c_CHAN_W'(NUM_CHAN - 1);
    localparam logic [c_PIX_CNT_W-1:0] c_LAST_PIX   = c_PIX_CNT_W'(c_TOTAL_PIX - 1);
    localparam logic [c_LATCH_W-1:0]   c_LAST_LATCH = c_LATCH_W'(LATCH_CYCLES - 1);
    localparam logic [c_STALL_W-1:0]   c_STALL_SAT  = c_STALL_W'(UNDERRUN_CYCLES);
    localparam logic [c_STALL_W-1:0]   c_STALL_HIT  = c_STALL_W'(UNDERRUN_CYCLES - 1);
    localparam logic [HBLANK_W-1:0]    c_HBLANK_ONE = HBLANK_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_SCALE  = 3'd3,
        S_SEND   = 3'd4,
        S_LATCH  = 3'd5,
        S_HBLANK = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CHAN_W-1:0]    r_chan;
    logic [c_PIX_CNT_W-1:0] r_pix_cnt;
    logic [c_STALL_W-1:0]   r_stall_cnt;
    logic [c_LATCH_W-1:0]   r_latch_cnt;
    logic [HBLANK_W-1:0]    r_hblank_cnt;
    logic [PIX_W-1:0]       r_ser_data;
    logic                   r_frame_done;
    logic [15:0]            r_frame_count;
    logic                   r_underrun;

    logic                   w_rd_en;
    logic                   w_frame_start;
    logic                   w_handshake;
    logic                   w_latch_done;
    logic                   w_stall;
    logic                   w_stall_hit;

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!bus.fifo_empty) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef LED_SCHED_BRIGHTNESS_EN
                w_state_nxt = S_SCALE;
`else
                w_state_nxt = S_SEND;
`endif
            end
            S_SCALE: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (bus.ser_ready) begin
                    w_state_nxt = (r_pix_cnt == c_LAST_PIX) ? S_LATCH : S_FETCH;
                end
            end
            S_LATCH: begin
                if (r_latch_cnt == c_LAST_LATCH) begin
                    w_state_nxt = S_HBLANK;
                end
            end
            S_HBLANK: begin
                // A captured gap of 0 or 1 both leave after this single cycle.
                if (r_hblank_cnt <= c_HBLANK_ONE) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_frame_start = (r_state == S_IDLE) && enable;
    assign w_handshake   = (r_state == S_SEND) && bus.ser_ready;
    assign w_latch_done  = (r_state == S_LATCH) && (r_latch_cnt == c_LAST_LATCH);
    assign w_stall       = (r_state == S_FETCH) && bus.fifo_empty;
    assign w_stall_hit   = w_stall && (r_stall_cnt == c_STALL_HIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Channel / pixel position within the frame
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chan    <= '0;
            r_pix_cnt <= '0;
        end else if (w_frame_start) begin
            r_chan    <= '0;
            r_pix_cnt <= '0;
        end else if (w_handshake) begin
            r_chan    <= (r_chan == c_LAST_CHAN) ? '0 : r_chan + 1'b1;
            r_pix_cnt <= r_pix_cnt + 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Starvation counter (saturating) and sticky underrun flag.
    // A new underrun event takes priority over a clear in the same cycle.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_frame_start || w_rd_en) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != c_STALL_SAT)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
        end else if (w_stall_hit) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

    //--------------------------------------------------------------------------
    // Pixel data path
    //--------------------------------------------------------------------------
`ifdef LED_SCHED_BRIGHTNESS_EN
    logic [PIX_W-1:0] w_scaled;

    for (genvar g = 0; g < PIX_W / 8; g++) begin : g_scale
        logic [15:0] w_prod;
        // 8b x 9b fits in 16 bits: 255 * 256 = 0xFF00
        assign w_prod = {8'd0, r_ser_data[g*8 +: 8]} * ({8'd0, brightness} + 16'd1);
        assign w_scaled[g*8 +: 8] = w_prod[15:8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ser_data <= '0;
        end else if (r_state == S_LOAD) begin
            r_ser_data <= bus.fifo_rd_data;
        end else if (r_state == S_SCALE) begin
            r_ser_data <= w_scaled;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ser_data <= '0;
        end else if (r_state == S_LOAD) begin
            r_ser_data <= bus.fifo_rd_data;
        end
    end
`endif

    //--------------------------------------------------------------------------
    // Latch period, frame accounting and inter-frame gap.
    // hblank_cycles is captured only at latch exit, so register writes during
    // a frame apply to the following gap.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_latch_cnt <= '0;
        end else if ((r_state == S_LATCH) && !w_latch_done) begin
            r_latch_cnt <= r_latch_cnt + 1'b1;
        end else begin
            r_latch_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_hblank_cnt  <= '0;
        end else begin
            r_frame_done <= w_latch_done;
            if (w_latch_done) begin
                r_frame_count <= r_frame_count + 16'd1;
                r_hblank_cnt  <= hblank_cycles;
            end else if ((r_state == S_HBLANK) && (r_hblank_cnt > c_HBLANK_ONE)) begin
                r_hblank_cnt <= r_hblank_cnt - 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign bus.fifo_rd_en = w_rd_en;
    assign bus.ser_valid  = (r_state == S_SEND);
    assign bus.ser_chan   = r_chan;
    assign bus.ser_data   = r_ser_data;
    assign bus.ser_latch  = (r_state == S_LATCH);

    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign underrun    = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_led_frame_sched.sv
//==============================================================================
// Module      : tb_led_frame_sched
// Description : Directed self-checking bench for led_frame_sched with
//               NUM_CHAN=2, LEDS_PER_CHAN=4, LATCH_CYCLES=16,
//               UNDERRUN_CYCLES=32. Inputs change 1 ns after the rising edge;
//               a falling-edge monitor logs serializer handshakes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_led_frame_sched;

`ifdef LED_SCHED_BRIGHTNESS_EN
    localparam int c_LAT = 3;
`else
    localparam int c_LAT = 2;
`endif

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        enable       = 1'b0;
    logic        underrun_clr = 1'b0;
    logic [15:0] hblank_cycles = 16'd0;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        underrun;
`ifdef LED_SCHED_BRIGHTNESS_EN
    logic [7:0]  brightness = 8'hFF;
`endif

    led_frame_sched_if #(.NUM_CHAN(2), .PIX_W(24)) bus();

    led_frame_sched #(
        .NUM_CHAN        (2),
        .PIX_W           (24),
        .LEDS_PER_CHAN   (4),
        .LATCH_CYCLES    (16),
        .UNDERRUN_CYCLES (32),
        .HBLANK_W        (16)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .hblank_cycles (hblank_cycles),
`ifdef LED_SCHED_BRIGHTNESS_EN
        .brightness    (brightness),
`endif
        .underrun_clr  (underrun_clr),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_count   (frame_count),
        .underrun      (underrun),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // ---------------- pixel FIFO model ----------------
    logic [23:0] fifo_mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
            bus.fifo_rd_data <= fifo_mem[rd_ptr % 64];
            rd_ptr           <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [23:0] v);
        fifo_mem[wr_ptr % 64] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          last_rd = 0;
    int          cur_lat = 0;
    logic        prev_valid = 1'b0;
    int          log_n = 0;
    logic [23:0] log_data [0:255];
    logic [0:0]  log_chan [0:255];
    int          log_lat  [0:255];
    int          fd_cnt = 0;
    int          latch_n = 0;
    int          rd_n = 0;
    int          viol_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_valid <= bus.ser_valid;
        if (bus.fifo_rd_en) begin
            last_rd <= cyc;
            rd_n    <= rd_n + 1;
        end
        if (bus.fifo_rd_en && bus.ser_valid) viol_n <= viol_n + 1;
        if (bus.ser_valid && !prev_valid) cur_lat <= cyc - last_rd;
        if (bus.ser_valid && bus.ser_ready && (log_n < 256)) begin
            log_data[log_n] <= bus.ser_data;
            log_chan[log_n] <= bus.ser_chan;
            log_lat[log_n]  <= (!prev_valid) ? (cyc - last_rd) : cur_lat;
            log_n           <= log_n + 1;
        end
        if (frame_done)    fd_cnt  <= fd_cnt + 1;
        if (bus.ser_latch) latch_n <= latch_n + 1;
    end

    // ---------------- checking ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_value({pfx, "_busy"},        32'(busy),          32'd0);
        check_value({pfx, "_frame_done"},  32'(frame_done),    32'd0);
        check_value({pfx, "_frame_count"}, 32'(frame_count),   32'd0);
        check_value({pfx, "_underrun"},    32'(underrun),      32'd0);
        check_value({pfx, "_rd_en"},       32'(bus.fifo_rd_en),32'd0);
        check_value({pfx, "_ser_valid"},   32'(bus.ser_valid), 32'd0);
        check_value({pfx, "_ser_latch"},   32'(bus.ser_latch), 32'd0);
        check_value({pfx, "_ser_data"},    32'(bus.ser_data),  32'd0);
        check_value({pfx, "_ser_chan"},    32'(bus.ser_chan),  32'd0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.ser_valid && n < 200) begin step(); n++; end
        check_value("wait_valid", 32'(bus.ser_valid), 32'd1);
    endtask

    task automatic wait_frame_done();
        int n = 0;
        while (!frame_done && n < 400) begin step(); n++; end
        check_value("wait_frame_done", 32'(frame_done), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin step(); n++; end
        check_value("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_log(input int target);
        int n = 0;
        while (log_n < target && n < 400) begin step(); n++; end
        check_value("wait_log", 32'(log_n >= target), 32'd1);
    endtask

    task automatic start_frame();
        enable = 1'b1;
        step();
        enable = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int base;
    int snap;
    int t0;
    int t1;
    int stable;

    initial begin
        bus.ser_ready = 1'b0;

        // 1: reset state, then reset in the middle of SEND
        repeat (3) step();
        check_outputs_zero("rst");
        rst_n = 1'b1;
        step();
        check_outputs_zero("post_rst");

        for (int i = 0; i < 8; i++) push(24'hA1 + 24'(i));
        start_frame();
        wait_valid();
        check_value("t1_px0_data", 32'(bus.ser_data), 32'h0000A1);
        bus.ser_ready = 1'b1;
        step();
        bus.ser_ready = 1'b0;
        wait_valid();
        check_value("t1_px1_chan", 32'(bus.ser_chan), 32'd1);
        check_value("t1_px1_data", 32'(bus.ser_data), 32'h0000A2);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("mid_rst");
        step();
        step();
        rst_n  = 1'b1;
        wr_ptr = rd_ptr;
        step();

        // 2: basic frame, round-robin channels, latch period
        for (int i = 1; i <= 8; i++) push(24'(i));
        bus.ser_ready = 1'b1;
        base = log_n;
        snap = latch_n;
        t0   = fd_cnt;
        start_frame();
        wait_frame_done();
        wait_idle();
        check_value("t2_pix_count", 32'(log_n - base), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check_value($sformatf("t2_data%0d", k), 32'(log_data[base+k]), 32'(k + 1));
            check_value($sformatf("t2_chan%0d", k), 32'(log_chan[base+k]), 32'(k % 2));
        end
        check_value("t2_latency", 32'(log_lat[base]), 32'(c_LAT));
        check_value("t2_latch_cycles", 32'(latch_n - snap), 32'd16);
        check_value("t2_frame_done_pulses", 32'(fd_cnt - t0), 32'd1);
        check_value("t2_frame_count", 32'(frame_count), 32'd1);

        // 3: backpressure at pixel 3
        for (int i = 0; i < 8; i++) push(24'h10 + 24'(i));
        bus.ser_ready = 1'b0;
        base = log_n;
        start_frame();
        for (int k = 0; k < 8; k++) begin
            wait_valid();
            if (k == 3) begin
                snap   = rd_n;
                stable = 0;
                for (int c = 0; c < 10; c++) begin
                    step();
                    if (bus.ser_valid && bus.ser_data == 24'h13 && bus.ser_chan == 1'b1) stable++;
                end
                check_value("t3_hold_stable", 32'(stable), 32'd10);
                check_value("t3_no_pop_while_held", 32'(rd_n - snap), 32'd0);
            end
            bus.ser_ready = 1'b1;
            step();
            bus.ser_ready = 1'b0;
        end
        wait_frame_done();
        wait_idle();
        check_value("t3_pix_count", 32'(log_n - base), 32'd8);
        check_value("t3_last_data", 32'(log_data[base+7]), 32'h17);
        check_value("t3_frame_count", 32'(frame_count), 32'd2);

        // 4: FIFO starvation after pixel 3
        for (int i = 0; i < 4; i++) push(24'h20 + 24'(i));
        bus.ser_ready = 1'b1;
        base = log_n;
        start_frame();
        wait_log(base + 4);
        // now in stall cycle 1
        repeat (31) step();
        check_value("t4_underrun_at_stall32", 32'(underrun), 32'd0);
        step();
        check_value("t4_underrun_after_stall32", 32'(underrun), 32'd1);
        repeat (7) step();
        for (int i = 4; i < 8; i++) push(24'h20 + 24'(i));
        wait_frame_done();
        wait_idle();
        check_value("t4_underrun_sticky", 32'(underrun), 32'd1);
        check_value("t4_pix_count", 32'(log_n - base), 32'd8);
        check_value("t4_last_data", 32'(log_data[base+7]), 32'h27);
        check_value("t4_last_chan", 32'(log_chan[base+7]), 32'd1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check_value("t4_underrun_cleared", 32'(underrun), 32'd0);

        // 4b: set and clear in the same cycle
        underrun_clr = 1'b1;
        start_frame();
        // stall cycle 1 of an empty-FIFO frame start
        repeat (31) step();
        check_value("t4b_before_set", 32'(underrun), 32'd0);
        step();
        check_value("t4b_set_wins", 32'(underrun), 32'd1);
        underrun_clr = 1'b0;
        for (int i = 0; i < 8; i++) push(24'h30 + 24'(i));
        wait_frame_done();
        wait_idle();
        check_value("t4b_frame_count", 32'(frame_count), 32'd4);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;

        // 5: hblank=5, changed to 0 during the gap; enable dropped at pixel 2
        hblank_cycles = 16'd5;
        for (int i = 0; i < 8; i++) push(24'h40 + 24'(i));
        base   = log_n;
        enable = 1'b1;
        wait_log(base + 2);
        enable = 1'b0;
        wait_frame_done();
        t0 = cyc;
        hblank_cycles = 16'd0;
        wait_idle();
        t1 = cyc;
        check_value("t5_hblank5_gap", 32'(t1 - t0), 32'd5);
        repeat (20) step();
        check_value("t5_stays_idle", 32'(busy), 32'd0);
        check_value("t5_full_frame", 32'(log_n - base), 32'd8);

        for (int i = 0; i < 8; i++) push(24'h50 + 24'(i));
        base   = log_n;
        enable = 1'b1;
        wait_log(base + 2);
        enable = 1'b0;
        wait_frame_done();
        t0 = cyc;
        wait_idle();
        t1 = cyc;
        check_value("t5_hblank0_gap", 32'(t1 - t0), 32'd1);
        repeat (20) step();
        check_value("t5b_stays_idle", 32'(busy), 32'd0);
        check_value("t5b_full_frame", 32'(log_n - base), 32'd8);
        check_value("t5_frame_count", 32'(frame_count), 32'd6);

        // 6: brightness stage / pass-through
`ifdef LED_SCHED_BRIGHTNESS_EN
        brightness = 8'h7F;
`endif
        push(24'hFF8002);
        for (int i = 1; i < 8; i++) push(24'h808080);
        base = log_n;
        start_frame();
        wait_frame_done();
        wait_idle();
`ifdef LED_SCHED_BRIGHTNESS_EN
        check_value("t6_px0", 32'(log_data[base]),   32'h7F4001);
        check_value("t6_px1", 32'(log_data[base+1]), 32'h404040);
`else
        check_value("t6_px0", 32'(log_data[base]),   32'hFF8002);
        check_value("t6_px1", 32'(log_data[base+1]), 32'h808080);
`endif
        check_value("t6_latency", 32'(log_lat[base]), 32'(c_LAT));
        check_value("t6_frame_count", 32'(frame_count), 32'd7);
        check_value("no_pop_during_valid", 32'(viol_n), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
